// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths and
// the request FSM state encoding.
package fetch_unit_pkg;

    localparam int WORD_W     = 16;
    localparam int FIFO_DEPTH = 4;

    // IDLE: no request outstanding. REQ: request to mem held until acked.
    // DISCARD: request whose data became stale after a redirect; it is
    // still held until acked, because requests are never retracted.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO holding {instr, imm, pc} entries for decode.
// Flush empties it in one cycle; a pop while empty is ignored. The caller
// guarantees that push never happens while full.
module fetch_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop = pop && (r_count != '0);
    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

    // Storage: cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush has priority over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues one-word fetches to memory and
// queues returned {instr, imm, pc} for decode. Redirects flush the queue
// and retarget the PC; a request already on the bus is drained and dropped.
// Optional feature macro FETCH_BYPASS_EN: when the queue is empty and decode
// is ready, an acked fetch is presented to decode in the same cycle.
//
// Handshakes: a memory transfer happens at a posedge where mem_req and
// mem_ack are both high; mem_req/mem_addr stay stable until then. A decode
// transfer happens at a posedge where out_valid and out_ready are both high.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter  int              WORD     = WORD_W,
    parameter  int              DEPTH    = FIFO_DEPTH,
    parameter  logic [WORD-1:0] RESET_PC = '0,
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [WORD-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_instr,
    input  logic [WORD-1:0] mem_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_instr,
    output logic [WORD-1:0] out_imm,
    output logic [WORD-1:0] out_pc,
    input  logic            redir_jump,
    input  logic            redir_rjump,
    input  logic [WORD-1:0] redir_loc,
    input  logic [WORD-1:0] redir_inc,
    input  logic [WORD-1:0] redir_pc,
    output logic [CW-1:0]   count,
    output logic [1:0]      dbg_state
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [WORD-1:0]   r_fetch_pc;
    logic [WORD-1:0]   w_fetch_pc_nxt;
    logic [WORD-1:0]   r_mem_addr;
    logic [WORD-1:0]   w_mem_addr_nxt;
    logic              w_redir;
    logic [WORD-1:0]   w_target;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_bypass;
    logic              w_stay_req;
    logic [CW-1:0]     w_count;
    logic [3*WORD-1:0] w_fifo_rdata;

    assign w_redir      = redir_jump | redir_rjump;
    // Word index/offset to byte address; jump wins when both pulse.
    assign w_target     = redir_jump ? (redir_loc << 1) : (redir_pc + (redir_inc << 1));
    assign w_fifo_empty = (w_count == '0);
    assign w_pop        = out_ready & ~w_fifo_empty;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = (r_state == ST_REQ) & mem_ack & ~w_redir & w_fifo_empty & out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    // Acked data is dropped on a redirect, and not queued when bypassed.
    assign w_push = (r_state == ST_REQ) & mem_ack & ~w_redir & ~w_bypass;
    // Keep requesting only if a slot is still free after this cycle's transfer.
    assign w_stay_req = w_bypass | w_pop | (w_count < (DEPTH_C - CW'(1)));

    // Request FSM state, fetch PC and bus address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // Next-state logic; in REQ the fetch PC equals the address on the bus.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            ST_IDLE: begin
                // No push can be pending here, so occupancy alone gives room.
                if (w_redir) begin
                    w_fetch_pc_nxt = w_target;
                end else if (w_count < DEPTH_C) begin
                    w_state_nxt    = ST_REQ;
                    w_mem_addr_nxt = r_fetch_pc;
                end
            end
            ST_REQ: begin
                if (w_redir) begin
                    w_fetch_pc_nxt = w_target;
                    w_state_nxt    = mem_ack ? ST_IDLE : ST_DISCARD;
                end else if (mem_ack) begin
                    w_fetch_pc_nxt = r_fetch_pc + WORD'(2);
                    if (w_stay_req) begin
                        w_mem_addr_nxt = r_fetch_pc + WORD'(2);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_redir) begin
                    w_fetch_pc_nxt = w_target;
                end
                if (mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .WIDTH (3 * WORD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_redir),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({mem_instr, mem_imm, r_mem_addr}),
        .rdata (w_fifo_rdata),
        .count (w_count)
    );

    // Decode-facing head: queue head, or the live ack when bypassing.
    always_comb begin
        out_valid                     = ~w_fifo_empty;
        {out_instr, out_imm, out_pc}  = w_fifo_rdata;
        if (w_bypass) begin
            out_valid = 1'b1;
            out_instr = mem_instr;
            out_imm   = mem_imm;
            out_pc    = r_mem_addr;
        end
    end

    assign mem_req   = (r_state != ST_IDLE);
    assign mem_addr  = r_mem_addr;
    assign count     = w_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory returns data derived from the address, the
// reference model is the program-order stream of byte addresses restarted
// at each redirect target, and a negedge monitor checks every decode pop.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int W = 16;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  logic mem_req, mem_ack;
  logic [W-1:0] mem_addr, mem_instr, mem_imm;
  logic out_valid, out_ready;
  logic [W-1:0] out_instr, out_imm, out_pc;
  logic redir_jump, redir_rjump;
  logic [W-1:0] redir_loc, redir_inc, redir_pc;
  logic [CW-1:0] count;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_pc = 16'h0000;

  always #5 clk = ~clk;

  fetch_unit #(.WORD(W), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_instr(mem_instr), .mem_imm(mem_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm(out_imm), .out_pc(out_pc),
    .redir_jump(redir_jump), .redir_rjump(redir_rjump),
    .redir_loc(redir_loc), .redir_inc(redir_inc), .redir_pc(redir_pc),
    .count(count), .dbg_state(dbg_state)
  );

  // Memory image: contents are a fixed function of the byte address.
  function automatic logic [W-1:0] instr_at(input logic [W-1:0] a);
    return (a * 16'd3) ^ 16'hA5A5;
  endfunction

  function automatic logic [W-1:0] imm_at(input logic [W-1:0] a);
    return {a[7:0], a[15:8]} + 16'h1234;
  endfunction

  assign mem_instr = instr_at(mem_addr);
  assign mem_imm = imm_at(mem_addr);

  function automatic logic [W-1:0] model_target(input logic j, input logic [W-1:0] loc,
                                                input logic [W-1:0] inc, input logic [W-1:0] pc);
    logic [W-1:0] t;
    if (j) t = loc * 16'd2;
    else t = pc + inc * 16'd2;
    return t;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_redirect(input logic [W-1:0] t);
    exp_q.delete();
    model_pc = t;
  endtask

  // ---------------- clock/reset ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack = 1'b0; out_ready = 1'b0;
    redir_jump = 1'b0; redir_rjump = 1'b0;
    model_redirect(16'h0000);
    #1;
    check("rst_mem_req", W'(mem_req), 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_out_valid", W'(out_valid), 16'h0);
    check("rst_out_instr", out_instr, 16'h0000);
    check("rst_out_imm", out_imm, 16'h0000);
    check("rst_out_pc", out_pc, 16'h0000);
    check("rst_count", W'(count), 16'h0);
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- driver: redirect while REQ is being acked ----------------
  task automatic redirect_check(input string name, input logic j, input logic rj,
                                input logic [W-1:0] loc, input logic [W-1:0] inc,
                                input logic [W-1:0] pc, input logic [W-1:0] exp_target);
    @(posedge clk); #1;
    redir_jump = j; redir_rjump = rj;
    redir_loc = loc; redir_inc = inc; redir_pc = pc;
    model_redirect(model_target(j, loc, inc, pc));
    @(posedge clk); #1;
    redir_jump = 1'b0; redir_rjump = 1'b0;
    check({name, "_req_low"}, W'(mem_req), 16'h0);
    check({name, "_flushed"}, W'(count), 16'h0);
    @(posedge clk); #1;
    check({name, "_req"}, W'(mem_req), 16'h1);
    check({name, "_addr"}, mem_addr, exp_target);
    @(posedge clk); #1;
    check({name, "_next"}, mem_addr, exp_target + 16'd2);
    repeat (3) @(posedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic prev_redir;
    logic prev_hold;
    logic [W-1:0] prev_addr;
    logic [W-1:0] e;
    prev_redir = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_redir = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_redir) begin
          check("flush_valid", W'(out_valid), 16'h0);
          check("flush_count", W'(count), 16'h0);
        end
        if (prev_hold) begin
          check("req_held", W'(mem_req), 16'h1);
          check("addr_stable", mem_addr, prev_addr);
        end
        check("count_bound", W'(count > CW'(DEPTH)), 16'h0);
        if (count != '0) check("valid_nonempty", W'(out_valid), 16'h1);
        if (out_valid && out_ready && !(redir_jump || redir_rjump)) begin
          while (exp_q.size() < 4) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 16'd2;
          end
          e = exp_q.pop_front();
          check("out_pc", out_pc, e);
          check("out_instr", out_instr, instr_at(e));
          check("out_imm", out_imm, imm_at(e));
          pops++;
        end
        prev_redir = redir_jump || redir_rjump;
        prev_hold = mem_req && !mem_ack;
        prev_addr = mem_addr;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p;
    int kind;
    rst = 1'b1;
    mem_ack = 1'b0; out_ready = 1'b0;
    redir_jump = 1'b0; redir_rjump = 1'b0;
    redir_loc = '0; redir_inc = '0; redir_pc = '0;

    // Streaming: ack every cycle, decode always ready.
    do_reset();
    mem_ack = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("p1_req", W'(mem_req), 16'h1);
    check("p1_addr0", mem_addr, 16'h0000);
`ifdef FETCH_BYPASS_EN
    check("byp_valid", W'(out_valid), 16'h1);
    check("byp_instr", out_instr, 16'hA5A5);
    check("byp_count", W'(count), 16'h0);
`else
    check("lat_valid0", W'(out_valid), 16'h0);
`endif
    @(posedge clk); @(negedge clk);
    check("p1_addr2", mem_addr, 16'h0002);
`ifndef FETCH_BYPASS_EN
    check("lat_valid1", W'(out_valid), 16'h1);
    check("lat_instr", out_instr, 16'hA5A5);
    check("lat_pc", out_pc, 16'h0000);
    check("lat_count", W'(count), 16'h1);
`endif
    @(posedge clk); @(negedge clk);
    check("p1_addr4", mem_addr, 16'h0004);
    @(posedge clk); @(negedge clk);
    check("p1_addr6", mem_addr, 16'h0006);
    @(posedge clk); #1;
    p = pops;
    repeat (8) @(posedge clk);
    #1;
    check("throughput", W'(pops - p), 16'd8);

    // Fill with decode stalled (reset while a request is outstanding).
    do_reset();
    mem_ack = 1'b1; out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("full_count", W'(count), 16'd4);
    check("full_req", W'(mem_req), 16'h0);
    check("full_valid", W'(out_valid), 16'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pop1_count", W'(count), 16'd3);
    check("pop1_req", W'(mem_req), 16'h0);
    @(posedge clk); #1;
    check("refill_req", W'(mem_req), 16'h1);
    check("refill_addr", mem_addr, 16'h0008);
    @(posedge clk); #1;
    check("refill_count", W'(count), 16'd4);
    check("refill_idle", W'(mem_req), 16'h0);

    // Jump while a request is waiting for its ack.
    mem_ack = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain_count", W'(count), 16'h0);
    check("pend_req", W'(mem_req), 16'h1);
    check("pend_addr", mem_addr, 16'h000A);
    redir_jump = 1'b1; redir_loc = 16'h0010;
    model_redirect(model_target(1'b1, 16'h0010, 16'h0000, 16'h0000));
    @(posedge clk); #1;
    redir_jump = 1'b0;
    check("disc_state", W'(dbg_state), W'(ST_DISCARD));
    check("disc_req", W'(mem_req), 16'h1);
    check("disc_addr", mem_addr, 16'h000A);
    check("disc_count", W'(count), 16'h0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    check("disc_drop_req", W'(mem_req), 16'h0);
    check("disc_drop_count", W'(count), 16'h0);
    @(posedge clk); #1;
    check("jump_req", W'(mem_req), 16'h1);
    check("jump_addr", mem_addr, 16'h0020);
    repeat (4) @(posedge clk);

    // Redirects coinciding with an ack.
    redirect_check("rjump_back", 1'b0, 1'b1, 16'h0000, 16'hFFFC, 16'h0030, 16'h0028);
    redirect_check("rjump_wrap", 1'b0, 1'b1, 16'h0000, 16'h0002, 16'hFFFE, 16'h0002);
    redirect_check("both", 1'b1, 1'b1, 16'h0003, 16'h0005, 16'h0100, 16'h0006);
    redirect_check("pc_wrap", 1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h0000, 16'hFFFE);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      mem_ack = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      redir_jump = 1'b0; redir_rjump = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        kind = $urandom_range(0, 2);
        redir_jump = (kind != 1);
        redir_rjump = (kind != 0);
        redir_loc = 16'($urandom);
        redir_inc = 16'($urandom_range(0, 63)) - 16'd32;
        redir_pc = 16'($urandom) & 16'hFFFE;
        model_redirect(model_target(redir_jump, redir_loc, redir_inc, redir_pc));
      end
    end
    @(posedge clk); #1;
    redir_jump = 1'b0; redir_rjump = 1'b0;
    mem_ack = 1'b1; out_ready = 1'b1;
    p = pops;
    repeat (12) @(posedge clk);
    #1;
    check("final_progress", W'(pops - p >= 8), 16'h1);
    check("random_progress", W'(pops > 600), 16'h1);

    // Final report.
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
